// File: rtl/arriba_unit.sv
// arriba_unit -- instruction sequencer for the arriba/abajo processor pair.
//
// Fetches instructions over a handshake bus, steps a six-state control FSM
// (FETCH, DECODE, EXECUTE, MEM, WRITE, HALT), owns the PC, the Z/C flags and
// an 8-deep circular return stack, and drives the datapath controls.
//
// Ports
//   clk_i, rst_i                    clock (rising edge), async active-low reset
//   inst_cyc_o/inst_stb_o/inst_ack_i instruction bus handshake
//   inst_adr_o [11:0]               instruction address (current PC)
//   op_e, func_e [2:0]              decoded opcode / function from abajo_unit
//   addr_e [11:0], disp_e [7:0]     jump target, branch displacement
//   carry_e, zero_e                 combinational ALU flags
//   RegWrt_c, ClkEn_e, op2_c        register write, clock enable, immediate select
//   RegMux_c [1:0]                  write-back source: 00 ALU, 01 data, 10 port
//   data_cyc_o/stb_o/we_o, data_ack_i  data memory bus
//   port_cyc_o/stb_o/we_o, port_ack_i  I/O port bus
//   wake_i                          leaves HALT
module arriba_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        inst_cyc_o,
  output logic        inst_stb_o,
  input  logic        inst_ack_i,
  output logic [11:0] inst_adr_o,
  input  logic [2:0]  op_e,
  input  logic [2:0]  func_e,
  input  logic [11:0] addr_e,
  input  logic [7:0]  disp_e,
  input  logic        carry_e,
  input  logic        zero_e,
  output logic        RegWrt_c,
  output logic        ClkEn_e,
  output logic        op2_c,
  output logic [1:0]  RegMux_c,
  output logic        data_cyc_o,
  output logic        data_stb_o,
  output logic        data_we_o,
  input  logic        data_ack_i,
  output logic        port_cyc_o,
  output logic        port_stb_o,
  output logic        port_we_o,
  input  logic        port_ack_i,
  input  logic        wake_i
);

  localparam logic [2:0] FETCH   = 3'd0;
  localparam logic [2:0] DECODE  = 3'd1;
  localparam logic [2:0] EXECUTE = 3'd2;
  localparam logic [2:0] MEM     = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;
  localparam logic [2:0] HALT    = 3'd5;

  localparam logic [2:0] OP_ALUI  = 3'b000;
  localparam logic [2:0] OP_ALUR  = 3'b001;
  localparam logic [2:0] OP_SHIFT = 3'b010;
  localparam logic [2:0] OP_MEM   = 3'b011;
  localparam logic [2:0] OP_BR    = 3'b100;
  localparam logic [2:0] OP_JUMP  = 3'b101;
  localparam logic [2:0] OP_MISC  = 3'b110;

  localparam int unsigned STACK_DEPTH = 8;

  logic [2:0]  state, state_nxt;
  logic [11:0] pc, pc_nxt, pc_inc, br_target, pop_val;
  logic        flag_z, flag_c;
  logic [2:0]  sp;
  logic [3:0]  cnt;
  logic [11:0] stack_mem [STACK_DEPTH];
  logic        push, pop;

  logic inst_stb, data_stb, data_we, port_stb, port_we;

  // Instruction classification from the live decoder outputs; the
  // instruction memory keeps them stable from the fetch ack until the
  // next fetch, so they are valid in every post-fetch state.
  logic is_alu, is_ldm, is_stm, is_inp, is_out, is_data, is_port;
  logic is_br, is_jmp, is_jsb, is_ret, is_wait, br_taken, mem_ack;
  logic ctl_active;

  always_comb begin
    is_alu  = (op_e == OP_ALUI) || (op_e == OP_ALUR) || (op_e == OP_SHIFT);
    is_ldm  = (op_e == OP_MEM)  && (func_e == 3'b000);
    is_stm  = (op_e == OP_MEM)  && (func_e == 3'b001);
    is_inp  = (op_e == OP_MEM)  && (func_e == 3'b010);
    is_out  = (op_e == OP_MEM)  && (func_e == 3'b011);
    is_data = is_ldm || is_stm;
    is_port = is_inp || is_out;
    is_br   = (op_e == OP_BR)   && !func_e[2];
    is_jmp  = (op_e == OP_JUMP) && (func_e == 3'b000);
    is_jsb  = (op_e == OP_JUMP) && (func_e == 3'b001);
    is_ret  = (op_e == OP_MISC) && (func_e == 3'b000);
    is_wait = (op_e == OP_MISC) && (func_e == 3'b001);
    mem_ack = is_data ? data_ack_i : port_ack_i;
  end

  always_comb begin
    br_taken = 1'b0;
    case (func_e[1:0])
      2'b00:   br_taken = flag_z;
      2'b01:   br_taken = !flag_z;
      2'b10:   br_taken = flag_c;
      default: br_taken = !flag_c;
    endcase
  end

  assign pc_inc    = pc + 12'd1;
  assign br_target = pc_inc + {{4{disp_e[7]}}, disp_e};
  // Popping an empty stack yields address zero and leaves the pointer alone.
  assign pop_val   = (cnt == 4'd0) ? '0 : stack_mem[sp - 3'd1];

  // PC only changes on a transition into FETCH.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    pop       = 1'b0;
    case (state)
      FETCH: begin
        // After reset the strobe is still low: the first edge only raises it.
        if (inst_stb && inst_ack_i) state_nxt = DECODE;
      end
      DECODE: state_nxt = EXECUTE;
      EXECUTE: begin
        if (is_alu) begin
          state_nxt = WRITE;
        end else if (is_data || is_port) begin
          state_nxt = MEM;
        end else if (is_wait) begin
          state_nxt = HALT;
        end else begin
          state_nxt = FETCH;
          if (is_br && br_taken) begin
            pc_nxt = br_target;
          end else if (is_jmp || is_jsb) begin
            pc_nxt = addr_e;
            push   = is_jsb;
          end else if (is_ret) begin
            pc_nxt = pop_val;
            pop    = 1'b1;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      MEM: begin
        if (mem_ack) begin
          if (is_ldm || is_inp) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = FETCH;
            pc_nxt    = pc_inc;
          end
        end
      end
      WRITE: begin
        state_nxt = FETCH;
        pc_nxt    = pc_inc;
      end
      HALT: begin
        if (wake_i) begin
          state_nxt = FETCH;
          pc_nxt    = pc_inc;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= FETCH;
      pc       <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      sp       <= '0;
      cnt      <= '0;
      inst_stb <= 1'b0;
      data_stb <= 1'b0;
      data_we  <= 1'b0;
      port_stb <= 1'b0;
      port_we  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      // Strobes are registered from the next state so they are glitch-free
      // and mutually exclusive by construction.
      inst_stb <= (state_nxt == FETCH);
      data_stb <= (state_nxt == MEM) && is_data;
      data_we  <= (state_nxt == MEM) && is_stm;
      port_stb <= (state_nxt == MEM) && is_port;
      port_we  <= (state_nxt == MEM) && is_out;
      if ((state == WRITE) && is_alu) begin
        flag_z <= zero_e;
        flag_c <= carry_e;
      end
      if (push) begin
        sp <= sp + 3'd1;
        if (cnt != 4'(STACK_DEPTH)) cnt <= cnt + 4'd1;
      end else if (pop && (cnt != 4'd0)) begin
        sp  <= sp - 3'd1;
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Stack storage needs no reset; validity is tracked by cnt. A push when
  // full lands on the oldest slot because sp simply wraps.
  always_ff @(posedge clk_i) begin
    if (push) stack_mem[sp] <= pc_inc;
  end

  assign ctl_active = (state == DECODE) || (state == EXECUTE) ||
                      (state == MEM)    || (state == WRITE);

  always_comb begin
    RegMux_c = 2'b00;
    if (ctl_active && is_ldm)      RegMux_c = 2'b01;
    else if (ctl_active && is_inp) RegMux_c = 2'b10;
  end

  assign op2_c      = ctl_active && (op_e == OP_ALUI);
  assign RegWrt_c   = (state == WRITE);
  assign ClkEn_e    = (state == WRITE);
  assign inst_adr_o = pc;
  assign inst_cyc_o = inst_stb;
  assign inst_stb_o = inst_stb;
  assign data_cyc_o = data_stb;
  assign data_stb_o = data_stb;
  assign data_we_o  = data_we;
  assign port_cyc_o = port_stb;
  assign port_stb_o = port_stb;
  assign port_we_o  = port_we;

endmodule
